// File: rtl/telem_pkg.sv
// Shared telemetry types and sizes for the target store, its write scheduler and readout.
// Latency: none (types only). Backpressure: none (types only).
package telem_pkg;

    localparam int NUM_TARGETS = 16;
    localparam int TARGET_W    = 4;
    localparam int COORD_W     = 8;
    localparam int PKT_W       = 4 * COORD_W;

    typedef struct packed {
        logic [COORD_W-1:0] t;
        logic [COORD_W-1:0] z;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } telem_coord_t;

    typedef enum logic {
        SCH_IDLE  = 1'b0,
        SCH_GRANT = 1'b1
    } sched_state_t;

    // Round-robin successor of channel g among n channels.
    function automatic int next_chan(input int g, input int n);
        return (g + 1) % n;
    endfunction

endpackage

// File: rtl/telem_update_scheduler_if.sv
// Sensor-channel request bus plus target-store write port of the update scheduler.
// Latency: n/a. Backpressure: req_ready per channel, store_busy from the store.
interface telem_update_scheduler_if import telem_pkg::*; #(
    parameter int NREQ = 4
);
    localparam int SRC_W = $clog2(NREQ);

    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*TARGET_W-1:0] req_target;
    logic [NREQ*PKT_W-1:0]    req_coord;
    logic                     store_busy;

    logic                     wr_en;
    logic [TARGET_W-1:0]      wr_sel;
    logic [COORD_W-1:0]       wr_x;
    logic [COORD_W-1:0]       wr_y;
    logic [COORD_W-1:0]       wr_z;
    logic [COORD_W-1:0]       wr_t;
    logic [SRC_W-1:0]         wr_src;
    logic [NUM_TARGETS-1:0]   populated;
    logic [NUM_TARGETS-1:0]   stale;

    modport master (
        output req_valid, req_target, req_coord, store_busy,
        input  req_ready, wr_en, wr_sel, wr_x, wr_y, wr_z, wr_t, wr_src, populated, stale
    );

    modport slave (
        input  req_valid, req_target, req_coord, store_busy,
        output req_ready, wr_en, wr_sel, wr_x, wr_y, wr_z, wr_t, wr_src, populated, stale
    );

endinterface

// File: rtl/telem_rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant searched from the channel after the last winner.
// Latency: grant is combinational; pointer advances on the edge after a grant. Backpressure: en=0 suppresses all grants.
module telem_rr_arbiter import telem_pkg::*; #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NREQ-1:0]  valid,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
            if (!grant_vld && en && valid[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_vld   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= IDX_W'(next_chan(int'(grant_idx), NREQ));
        end
    end

endmodule

// File: rtl/telem_update_scheduler.sv
// Round-robin owner of the target-store write port; tracks populated (and, with TELEM_AGE_EN, stale) targets.
// Latency: grant at cycle N gives wr_en at N+1. Backpressure: store_busy or rst drops all req_ready for that cycle.
module telem_update_scheduler import telem_pkg::*; #(
    parameter int NREQ = 4
`ifdef TELEM_AGE_EN
    ,
    parameter int AGE_LIMIT = 255
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    telem_update_scheduler_if.slave  bus,
    output sched_state_t             dbg_state
);

    localparam int SRC_W = $clog2(NREQ);

    logic [NREQ-1:0]        grant;
    logic [SRC_W-1:0]       grant_idx;
    logic                   grant_vld;
    logic [TARGET_W-1:0]    sel_target;
    telem_coord_t           sel_coord;

    logic                   wr_en_q;
    logic [TARGET_W-1:0]    wr_sel_q;
    telem_coord_t           wr_coord_q;
    logic [SRC_W-1:0]       wr_src_q;
    logic [NUM_TARGETS-1:0] populated_q;

    sched_state_t           state;
    sched_state_t           state_n;

    telem_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (!rst && !bus.store_busy),
        .valid     (bus.req_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign bus.req_ready = grant;

    always_comb begin
        sel_target = bus.req_target[int'(grant_idx)*TARGET_W +: TARGET_W];
        sel_coord  = telem_coord_t'(bus.req_coord[int'(grant_idx)*PKT_W +: PKT_W]);
    end

    // Payload registers hold their last value when no transfer happens.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q     <= 1'b0;
            wr_sel_q    <= '0;
            wr_coord_q  <= '0;
            wr_src_q    <= '0;
            populated_q <= '0;
        end else begin
            wr_en_q <= grant_vld;
            if (grant_vld) begin
                wr_sel_q                <= sel_target;
                wr_coord_q              <= sel_coord;
                wr_src_q                <= grant_idx;
                populated_q[sel_target] <= 1'b1;
            end
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_sel    = wr_sel_q;
    assign bus.wr_x      = wr_coord_q.x;
    assign bus.wr_y      = wr_coord_q.y;
    assign bus.wr_z      = wr_coord_q.z;
    assign bus.wr_t      = wr_coord_q.t;
    assign bus.wr_src    = wr_src_q;
    assign bus.populated = populated_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SCH_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = SCH_IDLE;
        if (grant_vld) begin
            state_n = SCH_GRANT;
        end
    end

    assign dbg_state = state;

`ifdef TELEM_AGE_EN
    localparam int CNT_W = $clog2(AGE_LIMIT + 1);

    logic [NUM_TARGETS-1:0] stale_flags;

    // Counters run for every target; stale is masked by populated so never-written targets stay quiet.
    for (genvar k = 0; k < NUM_TARGETS; k++) begin : g_age
        logic [CNT_W-1:0] age_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                age_cnt <= '0;
            end else if (grant_vld && (sel_target == TARGET_W'(k))) begin
                age_cnt <= '0;
            end else if (age_cnt != CNT_W'(AGE_LIMIT)) begin
                age_cnt <= age_cnt + 1'b1;
            end
        end

        assign stale_flags[k] = populated_q[k] && (age_cnt == CNT_W'(AGE_LIMIT));
    end

    assign bus.stale = stale_flags;
`else
    assign bus.stale = '0;
`endif

endmodule
